// File: rtl/lsu_byte_master.sv
// lsu_byte_master: serialises one CPU load/store into little-endian byte beats
// on an 8-bit synchronous RAM port, reassembles and extends load data, and
// returns exactly one response per accepted request.
// Optional build macro MISALIGN_TRAP_EN: when defined, misaligned half/word
// requests are rejected with resp_err instead of being performed bytewise.
module lsu_byte_master #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t state, state_next;

  logic              write_q;
  logic [1:0]        width_q;
  logic              sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [2:0]        beat_cnt, beat_cnt_next;
  logic [31:0]       load_buf, load_buf_next;

  logic              mem_en_next, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [7:0]        mem_wdata_next;
  logic              resp_valid_next, resp_err_next;
  logic [31:0]       resp_rdata_next;

  logic              accept, misaligned, bad_req, last_beat, capture;
  logic [2:0]        beats_q, next_beat;
  logic [1:0]        cap_lane;

  function automatic logic [2:0] beat_count(input logic [1:0] w);
    case (w)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] k);
    case (k)
      2'd0:    return d[7:0];
      2'd1:    return d[15:8];
      2'd2:    return d[23:16];
      default: return d[31:24];
    endcase
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] d, input logic [1:0] k,
                                              input logic [7:0] b);
    logic [31:0] r;
    r = d;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] w,
                                              input logic s);
    case (w)
      2'b00:   return {{24{s & d[7]}}, d[7:0]};
      2'b01:   return {{16{s & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign accept = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((req_width == 2'b01) && req_addr[0]) ||
                      ((req_width == 2'b11) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign bad_req   = (req_width == 2'b10) || misaligned;
  assign beats_q   = beat_count(width_q);
  assign last_beat = (beat_cnt == (beats_q - 3'd1));
  assign next_beat = beat_cnt + 3'd1;
  // Read data lags its beat by one cycle, so the lane being filled is one behind the beat counter.
  assign cap_lane  = beat_cnt[1:0] - 2'd1;
  assign capture   = ((state == S_ACCESS) && (beat_cnt != 3'd0)) || (state == S_DRAIN);

  // Next-state, next beat and next response computation; every register gets a default first.
  always_comb begin
    state_next      = state;
    beat_cnt_next   = beat_cnt;
    load_buf_next   = load_buf;
    mem_en_next     = 1'b0;
    mem_we_next     = 1'b0;
    mem_addr_next   = '0;
    mem_wdata_next  = '0;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = '0;

    if (capture) begin
      load_buf_next = insert_byte(load_buf, cap_lane, mem_rdata);
    end

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad_req) begin
            state_next      = S_RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            state_next     = S_ACCESS;
            beat_cnt_next  = 3'd0;
            load_buf_next  = '0;
            mem_en_next    = 1'b1;
            mem_we_next    = req_write;
            mem_addr_next  = req_addr;
            mem_wdata_next = req_wdata[7:0];
          end
        end
      end
      S_ACCESS: begin
        beat_cnt_next = next_beat;
        if (last_beat) begin
          if (write_q) begin
            state_next      = S_RESP;
            resp_valid_next = 1'b1;
          end else begin
            state_next = S_DRAIN;
          end
        end else begin
          mem_en_next    = 1'b1;
          mem_we_next    = write_q;
          mem_addr_next  = addr_q + ADDR_W'(next_beat);
          mem_wdata_next = byte_of(wdata_q, next_beat[1:0]);
        end
      end
      S_DRAIN: begin
        state_next      = S_RESP;
        resp_valid_next = 1'b1;
        resp_rdata_next = extend_load(load_buf_next, width_q, sign_q);
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs; handshake flags are derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      load_buf   <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_next;
      beat_cnt   <= beat_cnt_next;
      load_buf   <= load_buf_next;
      req_ready  <= (state_next == S_IDLE);
      busy       <= (state_next != S_IDLE);
      mem_en     <= mem_en_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      resp_valid <= resp_valid_next;
      resp_err   <= resp_err_next;
      resp_rdata <= resp_rdata_next;
    end
  end

  // Request fields are captured only on the accepting cycle and held for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      width_q <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state == S_IDLE) && accept) begin
      write_q <= req_write;
      width_q <= req_width;
      sign_q  <= req_sign;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

endmodule
